// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encoding and the command sequencer FSM states.
// Used by the combinational alu, alu_cmd_sequencer and their benches.
package alu_pkg;

  typedef logic [2:0] alu_op_t;

  localparam alu_op_t ALU_ADD = 3'b000;
  localparam alu_op_t ALU_SUB = 3'b001;
  localparam alu_op_t ALU_AND = 3'b010;
  localparam alu_op_t ALU_OR  = 3'b011;
  localparam alu_op_t ALU_XOR = 3'b100;
  localparam alu_op_t ALU_SLT = 3'b101;
  localparam alu_op_t ALU_SLL = 3'b110;
  localparam alu_op_t ALU_SRL = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } seq_state_t;

endpackage

// File: rtl/alu_cmd_fifo.sv
// Circular-buffer command FIFO with full/empty flags and an occupancy count.
// DEPTH must be a power of two so the pointers wrap by natural overflow.
module alu_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  // A full FIFO refuses pushes even when a pop happens in the same cycle.
  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  // Storage write; contents need no reset since count guards every read.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Buffers ALU commands, issues them one at a time on registered alu_* outputs,
// and returns each result with its tag on a valid/ready response port.
// Optional build macro: ALU_SEQ_STATS_EN adds handshake statistics counters.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both 1; a valid side keeps its payload stable until that edge.
module alu_cmd_sequencer
  import alu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4,
  parameter int TAG_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  alu_op_t           cmd_opcode,
  input  logic [DATA_W-1:0] cmd_a,
  input  logic [DATA_W-1:0] cmd_b,
  input  logic [TAG_W-1:0]  cmd_tag,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_result,
  output logic              resp_zero,
  output logic [TAG_W-1:0]  resp_tag,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output alu_op_t           alu_opcode,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_zero,
  output logic              busy
`ifdef ALU_SEQ_STATS_EN
  ,
  input  logic              stat_clr,
  output logic [31:0]       stat_ops,
  output logic [31:0]       stat_zero
`endif
);

  localparam int FW = 3 + 2 * DATA_W + TAG_W;
  localparam int CW = $clog2(DEPTH) + 1;

  seq_state_t        state;
  seq_state_t        state_nxt;
  logic              fifo_pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CW-1:0]     fifo_count;
  logic [FW-1:0]     fifo_rdata;
  logic [TAG_W-1:0]  tag_q;

  alu_cmd_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (FW)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (cmd_valid),
    .push_data ({cmd_opcode, cmd_a, cmd_b, cmd_tag}),
    .pop       (fifo_pop),
    .pop_data  (fifo_rdata),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign cmd_ready = !fifo_full;

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state: ISSUE always lasts one cycle; RESP waits for the consumer.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (!fifo_empty) state_nxt = ST_ISSUE;
      ST_ISSUE: state_nxt = ST_RESP;
      ST_RESP:  if (resp_ready) state_nxt = fifo_empty ? ST_IDLE : ST_ISSUE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // FSM outputs: pop the head when idle, or when the held response retires.
  always_comb begin
    fifo_pop = 1'b0;
    case (state)
      ST_IDLE: fifo_pop = !fifo_empty;
      ST_RESP: fifo_pop = resp_ready && !fifo_empty;
      default: fifo_pop = 1'b0;
    endcase
  end

  assign busy = (state != ST_IDLE) || (fifo_count != '0);

  // Issue registers: load the popped command, otherwise hold the last one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a      <= '0;
      alu_b      <= '0;
      alu_opcode <= ALU_ADD;
      tag_q      <= '0;
    end else if (fifo_pop) begin
      alu_opcode <= fifo_rdata[FW-1 -: 3];
      alu_a      <= fifo_rdata[TAG_W+DATA_W +: DATA_W];
      alu_b      <= fifo_rdata[TAG_W +: DATA_W];
      tag_q      <= fifo_rdata[TAG_W-1:0];
    end
  end

  // Response registers: capture at the end of ISSUE, retire on handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_valid  <= 1'b0;
      resp_result <= '0;
      resp_zero   <= 1'b0;
      resp_tag    <= '0;
    end else if (state == ST_ISSUE) begin
      resp_valid  <= 1'b1;
      resp_result <= alu_result;
      resp_zero   <= alu_zero;
      resp_tag    <= tag_q;
    end else if (state == ST_RESP && resp_ready) begin
      resp_valid  <= 1'b0;
    end
  end

`ifdef ALU_SEQ_STATS_EN
  logic resp_fire;
  assign resp_fire = resp_valid && resp_ready;

  // Saturating handshake counters; clear wins over a same-cycle increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_ops  <= '0;
      stat_zero <= '0;
    end else if (stat_clr) begin
      stat_ops  <= '0;
      stat_zero <= '0;
    end else if (resp_fire) begin
      if (stat_ops != '1) stat_ops <= stat_ops + 32'd1;
      if (resp_zero && stat_zero != '1) stat_zero <= stat_zero + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Bench for alu_cmd_sequencer: behavioural ALU on the alu_* bus, a negedge
// scoreboard fed by accepted commands, and one task per scenario.
module tb_alu_cmd_sequencer;
  import alu_pkg::*;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 4;
  localparam int TAG_W  = 4;
  localparam int EW     = 1 + DATA_W + TAG_W;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic [2:0]        cmd_opcode = '0;
  logic [DATA_W-1:0] cmd_a = '0;
  logic [DATA_W-1:0] cmd_b = '0;
  logic [TAG_W-1:0]  cmd_tag = '0;
  logic              resp_valid;
  logic              resp_ready = 1'b0;
  logic [DATA_W-1:0] resp_result;
  logic              resp_zero;
  logic [TAG_W-1:0]  resp_tag;
  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [2:0]        alu_opcode;
  logic [DATA_W-1:0] alu_result;
  logic              alu_zero;
  logic              busy;
`ifdef ALU_SEQ_STATS_EN
  logic              stat_clr = 1'b0;
  logic [31:0]       stat_ops;
  logic [31:0]       stat_zero;
`endif

  int tests_run = 0;
  int tests_failed = 0;
  int cycle = 0;
  int hs_count = 0;
  logic [EW-1:0]     exp_q[$];
  logic [DATA_W-1:0] obs_res[$];
  int                hs_cycle[$];
  logic              hold_chk = 1'b0;
  logic [EW-1:0]     hold_val = '0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1, "watchdog");
  end

  // ---------------- reference ALU ----------------
  function automatic logic [DATA_W-1:0] ref_alu(input logic [2:0] op,
                                                input logic [DATA_W-1:0] a,
                                                input logic [DATA_W-1:0] b);
    case (op)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return a ^ b;
      3'd5: return ($signed(a) < $signed(b)) ? DATA_W'(1) : DATA_W'(0);
      3'd6: return a << b[4:0];
      default: return a >> b[4:0];
    endcase
  endfunction

  assign alu_result = ref_alu(alu_opcode, alu_a, alu_b);
  assign alu_zero   = (alu_result == '0);

  alu_cmd_sequencer #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .TAG_W  (TAG_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_opcode  (cmd_opcode),
    .cmd_a       (cmd_a),
    .cmd_b       (cmd_b),
    .cmd_tag     (cmd_tag),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_result (resp_result),
    .resp_zero   (resp_zero),
    .resp_tag    (resp_tag),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_opcode  (alu_opcode),
    .alu_result  (alu_result),
    .alu_zero    (alu_zero),
    .busy        (busy)
`ifdef ALU_SEQ_STATS_EN
    ,
    .stat_clr    (stat_clr),
    .stat_ops    (stat_ops),
    .stat_zero   (stat_zero)
`endif
  );

  // ---------------- scoreboard ----------------
  // Sampled on the falling edge: a handshake seen here completes at the next rise.
  always @(negedge clk) begin
    logic [DATA_W-1:0] r;
    logic [EW-1:0]     e;
    if (rst_n) begin
      if (cmd_valid && cmd_ready) begin
        r = ref_alu(cmd_opcode, cmd_a, cmd_b);
        exp_q.push_back({(r == '0), r, cmd_tag});
      end
      if (hold_chk) begin
        tests_run++;
        if ({resp_zero, resp_result, resp_tag} !== hold_val || resp_valid !== 1'b1) begin
          tests_failed++;
          $display("FAIL resp_hold: got valid=%b {z,res,tag}=%h, required valid=1 %h",
                   resp_valid, {resp_zero, resp_result, resp_tag}, hold_val);
        end
      end
      hold_chk = resp_valid && !resp_ready;
      hold_val = {resp_zero, resp_result, resp_tag};
      if (resp_valid && resp_ready) begin
        tests_run++;
        if (exp_q.size() == 0) begin
          tests_failed++;
          $display("FAIL resp_unexpected: got result=%h tag=%h, required no response",
                   resp_result, resp_tag);
        end else begin
          e = exp_q.pop_front();
          if ({resp_zero, resp_result, resp_tag} !== e) begin
            tests_failed++;
            $display("FAIL resp_data: got {z,res,tag}=%h, required %h",
                     {resp_zero, resp_result, resp_tag}, e);
          end
        end
        obs_res.push_back(resp_result);
        hs_cycle.push_back(cycle);
        hs_count++;
      end
    end else begin
      hold_chk = 1'b0;
    end
  end

  // ---------------- driver tasks ----------------
  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send_cmd(input logic [2:0] op, input logic [DATA_W-1:0] a,
                          input logic [DATA_W-1:0] b, input logic [TAG_W-1:0] tag);
    int guard = 0;
    cmd_valid  = 1'b1;
    cmd_opcode = op;
    cmd_a      = a;
    cmd_b      = b;
    cmd_tag    = tag;
    @(negedge clk);
    while (!cmd_ready && guard < 300) begin
      guard++;
      @(negedge clk);
    end
    if (!cmd_ready) begin
      tests_run++;
      tests_failed++;
      $display("FAIL cmd_accept_timeout: got cmd_ready=0 for %0d cycles, required accept", guard);
    end
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int guard = 0;
    @(negedge clk);
    while ((exp_q.size() != 0 || busy) && guard < 500) begin
      guard++;
      @(negedge clk);
    end
    tests_run++;
    if (exp_q.size() != 0 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL drain_timeout: got %0d pending busy=%b, required 0 pending busy=0",
               exp_q.size(), busy);
    end
    @(posedge clk);
    #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    tests_run++;
    if (resp_valid !== 1'b0 || resp_result !== '0 || resp_zero !== 1'b0 || resp_tag !== '0) begin
      tests_failed++;
      $display("FAIL reset_resp: got v=%b res=%h z=%b tag=%h, required all 0",
               resp_valid, resp_result, resp_zero, resp_tag);
    end
    tests_run++;
    if (alu_a !== '0 || alu_b !== '0 || alu_opcode !== ALU_ADD) begin
      tests_failed++;
      $display("FAIL reset_alu: got a=%h b=%h op=%b, required 0 0 000", alu_a, alu_b, alu_opcode);
    end
    tests_run++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_flags: got cmd_ready=%b busy=%b, required 1 0", cmd_ready, busy);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_single_add();
    resp_ready = 1'b1;
    send_cmd(ALU_ADD, 32'd10, 32'd5, 4'd3);
    @(posedge clk);
    @(negedge clk);
    tests_run++;
    if (alu_a !== 32'd10 || alu_b !== 32'd5 || alu_opcode !== ALU_ADD || resp_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL add_issue: got a=%0d b=%0d op=%b v=%b, required 10 5 000 0",
               alu_a, alu_b, alu_opcode, resp_valid);
    end
    @(negedge clk);
    tests_run++;
    if (resp_valid !== 1'b1 || resp_result !== 32'd15 || resp_zero !== 1'b0 || resp_tag !== 4'd3) begin
      tests_failed++;
      $display("FAIL add_resp: got v=%b res=%0d z=%b tag=%0d, required 1 15 0 3",
               resp_valid, resp_result, resp_zero, resp_tag);
    end
    wait_drain();
  endtask

  task automatic test_sub_zero();
    int guard = 0;
`ifdef ALU_SEQ_STATS_EN
    stat_clr = 1'b1;
    @(posedge clk);
    #1;
    stat_clr = 1'b0;
`endif
    resp_ready = 1'b1;
    send_cmd(ALU_SUB, 32'd5, 32'd5, 4'd9);
    @(negedge clk);
    while (!resp_valid && guard < 20) begin
      guard++;
      @(negedge clk);
    end
    tests_run++;
    if (resp_valid !== 1'b1 || resp_result !== '0 || resp_zero !== 1'b1 || resp_tag !== 4'd9) begin
      tests_failed++;
      $display("FAIL sub_zero: got v=%b res=%h z=%b tag=%0d, required 1 0 1 9",
               resp_valid, resp_result, resp_zero, resp_tag);
    end
    wait_drain();
`ifdef ALU_SEQ_STATS_EN
    tests_run++;
    if (stat_ops !== 32'd1 || stat_zero !== 32'd1) begin
      tests_failed++;
      $display("FAIL stats: got ops=%0d zero=%0d, required 1 1", stat_ops, stat_zero);
    end
`endif
  endtask

  task automatic test_backpressure();
    logic [DATA_W-1:0] want [5];
    want = '{32'h0000_0000, 32'hFFFF_FFFF, 32'hFF00_FF00, 32'h0000_0001, 32'h0000_0010};
    resp_ready = 1'b0;
    obs_res.delete();
    send_cmd(ALU_AND, 32'hF0F0_F0F0, 32'h0F0F_0F0F, 4'd1);
    send_cmd(ALU_OR,  32'hF0F0_F0F0, 32'h0F0F_0F0F, 4'd2);
    send_cmd(ALU_XOR, 32'hFFFF_0000, 32'h00FF_FF00, 4'd3);
    send_cmd(ALU_SLT, 32'd3, 32'd7, 4'd4);
    send_cmd(ALU_SLL, 32'd1, 32'd4, 4'd5);
    @(negedge clk);
    tests_run++;
    if (cmd_ready !== 1'b0 || busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL bp_full: got cmd_ready=%b busy=%b, required 0 1", cmd_ready, busy);
    end
    tests_run++;
    if (resp_valid !== 1'b1 || resp_tag !== 4'd1 || resp_result !== '0) begin
      tests_failed++;
      $display("FAIL bp_head: got v=%b tag=%0d res=%h, required 1 1 0",
               resp_valid, resp_tag, resp_result);
    end
    repeat (5) @(negedge clk);
    tests_run++;
    if (cmd_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL bp_still_full: got cmd_ready=%b, required 0", cmd_ready);
    end
    @(posedge clk);
    #1;
    resp_ready = 1'b1;
    wait_drain();
    tests_run++;
    if (obs_res.size() != 5) begin
      tests_failed++;
      $display("FAIL bp_count: got %0d responses, required 5", obs_res.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        tests_run++;
        if (obs_res[i] !== want[i]) begin
          tests_failed++;
          $display("FAIL bp_result[%0d]: got %h, required %h", i, obs_res[i], want[i]);
        end
      end
    end
  endtask

  task automatic test_streaming();
    resp_ready = 1'b1;
    hs_cycle.delete();
    for (int i = 0; i < 8; i++)
      send_cmd(3'($urandom_range(0, 7)), $urandom, DATA_W'($urandom_range(0, 31)), TAG_W'(i));
    wait_drain();
    tests_run++;
    if (hs_cycle.size() != 8) begin
      tests_failed++;
      $display("FAIL stream_count: got %0d responses, required 8", hs_cycle.size());
    end else begin
      for (int i = 1; i < 8; i++) begin
        tests_run++;
        if (hs_cycle[i] - hs_cycle[i-1] != 2) begin
          tests_failed++;
          $display("FAIL stream_gap[%0d]: got %0d cycles, required 2", i, hs_cycle[i] - hs_cycle[i-1]);
        end
      end
      tests_run++;
      if (cycle - 1 - hs_cycle[7] != 1) begin
        tests_failed++;
        $display("FAIL stream_busy_fall: got %0d cycles after last handshake, required 1",
                 cycle - 1 - hs_cycle[7]);
      end
    end
  endtask

  task automatic test_wrap();
    bit done = 1'b0;
    int start_hs = hs_count;
    fork
      begin
        for (int i = 0; i < 3 * DEPTH; i++) begin
          logic [DATA_W-1:0] a, b;
          a = (($urandom_range(0, 3) == 0) ? DATA_W'($urandom_range(0, 7)) : DATA_W'($urandom));
          b = (($urandom_range(0, 2) == 0) ? a : DATA_W'($urandom_range(0, 40)));
          send_cmd(3'($urandom_range(0, 7)), a, b, TAG_W'($urandom));
          repeat ($urandom_range(0, 2)) @(posedge clk);
          #1;
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1;
          resp_ready = ($urandom_range(0, 2) != 0);
        end
      end
    join
    resp_ready = 1'b1;
    wait_drain();
    tests_run++;
    if (hs_count - start_hs != 3 * DEPTH) begin
      tests_failed++;
      $display("FAIL wrap_count: got %0d responses, required %0d", hs_count - start_hs, 3 * DEPTH);
    end
  endtask

  task automatic test_reset_mid();
    int guard = 0;
    int hs_before;
    resp_ready = 1'b0;
    send_cmd(ALU_OR,  32'h1234_0000, 32'h0000_5678, 4'd7);
    send_cmd(ALU_XOR, 32'hAAAA_AAAA, 32'h5555_5555, 4'd8);
    send_cmd(ALU_SLL, 32'd3, 32'd2, 4'd9);
    @(negedge clk);
    while (!resp_valid && guard < 20) begin
      guard++;
      @(negedge clk);
    end
    tests_run++;
    if (resp_valid !== 1'b1 || alu_opcode !== ALU_OR) begin
      tests_failed++;
      $display("FAIL rst_mid_pre: got v=%b op=%b, required 1 011", resp_valid, alu_opcode);
    end
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    tests_run++;
    if (resp_valid !== 1'b0 || alu_opcode !== ALU_ADD || alu_a !== '0 || cmd_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL rst_mid_async: got v=%b op=%b a=%h rdy=%b, required 0 000 0 1",
               resp_valid, alu_opcode, alu_a, cmd_ready);
    end
    hs_before = hs_count;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    resp_ready = 1'b1;
    repeat (10) @(negedge clk);
    tests_run++;
    if (hs_count != hs_before || resp_valid !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL rst_mid_after: got %0d responses v=%b busy=%b rdy=%b, required 0 0 0 1",
               hs_count - hs_before, resp_valid, busy, cmd_ready);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_single_add();
    test_sub_zero();
    test_backpressure();
    test_streaming();
    test_wrap();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
